count_seg7_display: RTL and testbench
=====================================

COUNT_SEG7_DISPLAY -- requirements
Module: count_seg7_display

Interface
REQ-001 SHALL have one parameter: SCAN_DIV, default 4, clock cycles each digit is displayed (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 clears all state immediately).
REQ-004 SHALL have port count  input  4  binary value from the upstream 4-bit up counter, 0..15.
REQ-005 SHALL have port seg  output  7  segment drive, active-high, seg[0]=a … seg[6]=g.
REQ-006 SHALL have port an  output  2  digit enable, active-high one-hot: 2'b01 = units, 2'b10 = tens.
REQ-007 SHALL have port wrap  output  1  one-cycle pulse on a detected 15->0 wrap.
REQ-008 SHALL have port wrap_cnt  output  8  number of wraps seen, saturating.

Function
REQ-009 SHALL register count into count_q every cycle; one-cycle input latency.
REQ-010 SHALL hold count_prev, the previous count_q value, updated every cycle.
REQ-011 SHALL split count_q into tens = (count_q >= 10) and units = count_q - 10*tens.
REQ-012 SHALL run a scan FSM with states S_UNITS and S_TENS, plus divider div, 8 bits, range 0..SCAN_DIV-1.
REQ-013 SHALL increment div every cycle; at div = SCAN_DIV-1, div SHALL return to 0 and the state SHALL toggle; SCAN_DIV=1 toggles every cycle.
REQ-014 SHALL drive an=01 in S_UNITS and an=10 in S_TENS; an SHALL never be 00 or 11 outside reset.
REQ-015 SHALL encode the selected digit as 0:0x3F 1:0x06 2:0x5B 3:0x4F 4:0x66 5:0x6D 6:0x7D 7:0x07 8:0x7F 9:0x6F.
REQ-016 SHALL derive seg and an combinationally from state and count_q only, with no direct path from count.
REQ-017 SHALL assert wrap for exactly one cycle, on the cycle when count_prev=15 and count_q=0; no other transition asserts it.
REQ-018 SHALL increment wrap_cnt on each wrap pulse; at 255 it SHALL hold 255.
REQ-019 SHALL continue the scan unaffected by count changes; a digit change mid-slot SHALL appear on the next cycle without restarting div.

Reset
REQ-020 SHALL, while rst=0, force count_q=0, count_prev=0, div=0, state=S_UNITS, wrap=0, wrap_cnt=0, hence seg=0x3F and an=01.
REQ-021 SHALL clear all state on rst assertion at any point mid-scan or mid-pulse, without waiting for a clock edge.
REQ-022 SHALL NOT raise a false wrap on the first cycles after rst release, because count_prev is 0.

Configuration
REQ-023 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-024 SHALL, when LEADING_ZERO_BLANK_EN is defined, drive seg=0x00 in S_TENS whenever tens=0; an still follows REQ-014.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is undefined, drive seg=0x3F in S_TENS whenever tens=0.

Verification
REQ-026 SHALL cover reset: rst=0 at any time -> seg=0x3F, an=01, wrap=0, wrap_cnt=0 with no clock edge required.
REQ-027 SHALL cover a scan with count=7 held and SCAN_DIV=4 -> an alternates 01/10 every 4 cycles; units seg=0x07; tens seg=0x3F (0x00 with LEADING_ZERO_BLANK_EN).
REQ-028 SHALL cover two-digit display: count=13 -> units slot seg=0x4F, tens slot seg=0x06.
REQ-029 SHALL cover wrap: count 14,15,0,1 on consecutive cycles -> wrap=1 for exactly one cycle, the cycle after 0 is sampled; wrap_cnt 0->1.
REQ-030 SHALL cover saturation: 300 wraps -> wrap_cnt reaches 255 and holds; wrap still pulses each time.
REQ-031 SHALL cover reset mid-run: rst=0 during S_TENS with wrap_cnt=5 -> immediate clear; after release with count=0, no wrap pulse and an=01.

Source files
------------

// File: rtl/count_seg7_display.sv
// Two-digit multiplexed 7-segment driver for a 4-bit counter, with 15->0 wrap detection and a saturating wrap counter.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module count_seg7_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap,
  output logic [7:0] wrap_cnt
);

  typedef enum logic {S_UNITS, S_TENS} state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] count_q, count_prev_q;
  logic [7:0] wrap_cnt_q, wrap_cnt_d;
  logic       tens;
  logic [3:0] units;

  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_UNITS;
      div_q        <= 8'd0;
      count_q      <= 4'd0;
      count_prev_q <= 4'd0;
      wrap_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      count_q      <= count;
      count_prev_q <= count_q;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  // Scan divider runs freely; digit changes never restart it.
  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    if (div_q == DIV_LAST) begin
      div_d   = 8'd0;
      state_d = (state_q == S_UNITS) ? S_TENS : S_UNITS;
    end
  end

  assign tens  = (count_q >= 4'd10);
  assign units = tens ? (count_q - 4'd10) : count_q;

  always_comb begin
    an  = 2'b01;
    seg = seg7_encode(units);
    if (state_q == S_TENS) begin
      an = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
      seg = tens ? seg7_encode(4'd1) : 7'h00;
`else
      seg = seg7_encode({3'b000, tens});
`endif
    end
  end

  // count_prev_q resets to 0, so no false wrap right after reset release.
  assign wrap = (count_prev_q == 4'hF) && (count_q == 4'h0);

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_seg7_display.sv
// Scoreboard bench for count_seg7_display: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_count_seg7_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic [7:0] wrap_cnt;

  count_seg7_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .seg      (seg),
    .an       (an),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap;
    logic [7:0] wcnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: edges since reset release, sampled values, wraps seen.
  int         n_edges;
  int         cur_v;
  int         prev_v;
  int         wraps;
  logic [3:0] drv;
  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, {25'd0, seg}, 32'h3F);
    check({tag, "_an"}, {30'd0, an}, 32'h1);
    check({tag, "_wrap"}, {31'd0, wrap}, 32'h0);
    check({tag, "_wcnt"}, {24'd0, wrap_cnt}, 32'h0);
  endtask

  task automatic model_reset();
    n_edges = 0;
    cur_v   = 0;
    prev_v  = 0;
    wraps   = 0;
    drv     = 4'd0;
  endtask

  task automatic step(input logic [3:0] v);
    exp_t e;
    bit   tens_slot;
    int   digit;
    @(posedge clk);
    #1;
    prev_v    = cur_v;
    cur_v     = int'(drv);
    n_edges++;
    tens_slot = ((n_edges / SCAN_DIV) % 2) == 1;
    e.an      = tens_slot ? 2'b10 : 2'b01;
    digit     = tens_slot ? (cur_v / 10) : (cur_v % 10);
    e.seg     = seg_tab[digit];
`ifdef LEADING_ZERO_BLANK_EN
    if (tens_slot && digit == 0) e.seg = 7'h00;
`endif
    e.wrap = (prev_v == 15) && (cur_v == 0);
    e.wcnt = 8'((wraps > 255) ? 255 : wraps);
    if (e.wrap) wraps++;
    q.push_back(e);
    count = v;
    drv   = v;
  endtask

  task automatic do_reset(input string tag, input int hold);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    count = 4'd0;
    #1;
    check_reset_outputs(tag);
    repeat (hold) @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("seg", {25'd0, seg}, {25'd0, e.seg});
      check("an", {30'd0, an}, {30'd0, e.an});
      check("wrap", {31'd0, wrap}, {31'd0, e.wrap});
      check("wrap_cnt", {24'd0, wrap_cnt}, {24'd0, e.wcnt});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("init_rst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;

    repeat (20) step(4'd7);
    repeat (12) step(4'd13);
    step(4'd14); step(4'd15); step(4'd0); step(4'd1); step(4'd1);
    repeat (200) step(4'($urandom_range(0, 15)));

    do_reset("rst_a", 1);
    repeat (5) begin step(4'd15); step(4'd0); end
    step(4'd0); step(4'd0);
    while (((n_edges + 1) / SCAN_DIV) % 2 != 1) step(4'd0);
    @(posedge clk);
    #1;
    check("pre_rst_an", {30'd0, an}, 32'h2);
    check("pre_rst_wcnt", {24'd0, wrap_cnt}, 32'd5);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_scan_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    repeat (10) step(4'd0);

    repeat (300) begin step(4'd15); step(4'd0); end
    repeat (3) step(4'd0);

    step(4'd15); step(4'd0);
    do_reset("mid_pulse_rst", 0);
    repeat (50) step(4'($urandom_range(0, 15)));

    @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
